pkt_sync_fifo: RTL

Parametrised single-clock FIFO carrying framed words (data + sop + eop) between pipeline stages of the coder, e.g. DCT output to quantiser or the entropy coder output to the bit packer. It generalises the plain FIFO write/read ports with configurable width and depth, an almost-full threshold, occupancy and packet counters, sticky error flags, and an optional store-and-forward packet mode that holds a packet on the read side until its eop has been written.

---
 rtl/pkt_sync_fifo.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pkt_sync_fifo.sv
// Single-clock FIFO for framed words (data + sop + eop) with level/packet counters,
// sticky error flags and an optional store-and-forward read gate.
module pkt_sync_fifo #(
    parameter int DATA_WIDTH  = 12,
    parameter int DEPTH       = 16,
    parameter int AFULL_LEVEL = DEPTH - 2,
    parameter int PKT_MODE    = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_WIDTH-1:0]      wr_data,
    input  logic                       wr_sop,
    input  logic                       wr_eop,
    input  logic                       wr_valid,
    output logic                       wr_full,
    output logic                       wr_afull,
    input  logic                       rd_en,
    output logic [DATA_WIDTH-1:0]      rd_data,
    output logic                       rd_sop,
    output logic                       rd_eop,
    output logic                       rd_valid,
    output logic                       rd_empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     pkt_cnt,
    output logic                       err_ovf,
    output logic                       err_udf,
    output logic                       err_frame,
    output logic                       frame_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int MW = DATA_WIDTH + 2;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_IN_PKT = 1'b1
    } frame_state_e;

    // Handshake: a write is taken on a clk edge when wr_valid && !wr_full; a read is
    // taken when rd_en && !rd_empty and its word shows on rd_* with rd_valid one cycle later.

    logic [MW-1:0]         mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic [LW-1:0]         pkt_cnt_q, pkt_cnt_d;
    frame_state_e          state_q, state_d;
    logic                  err_ovf_q, err_udf_q, err_frame_q;
    logic                  frame_viol;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_sop_q, rd_eop_q, rd_valid_q;
    logic                  wr_acc, rd_acc;
    logic [MW-1:0]         rd_word;
    logic                  wr_eop_acc, rd_eop_acc;

    assign wr_full  = (level_q == LW'(DEPTH));
    assign wr_afull = (level_q >= LW'(AFULL_LEVEL));
    // A full FIFO with no complete packet still releases reads so oversize packets drain.
    assign rd_empty = (level_q == '0) ||
                      ((PKT_MODE != 0) && (pkt_cnt_q == '0) && !wr_full);

    assign wr_acc     = wr_valid && !wr_full;
    assign rd_acc     = rd_en && !rd_empty;
    assign rd_word    = mem_q[rd_ptr_q];
    assign wr_eop_acc = wr_acc && wr_eop;
    assign rd_eop_acc = rd_acc && rd_word[DATA_WIDTH];

    always_comb begin
        level_d = level_q;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        pkt_cnt_d = pkt_cnt_q;
        if (wr_eop_acc && !rd_eop_acc) begin
            pkt_cnt_d = pkt_cnt_q + LW'(1);
        end else if (!wr_eop_acc && rd_eop_acc) begin
            pkt_cnt_d = pkt_cnt_q - LW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_viol = 1'b0;
        if (wr_acc) begin
            case (state_q)
                S_IDLE: begin
                    frame_viol = !wr_sop;
                    state_d    = wr_eop ? S_IDLE : S_IN_PKT;
                end
                S_IN_PKT: begin
                    frame_viol = wr_sop;
                    state_d    = wr_eop ? S_IDLE : S_IN_PKT;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= {wr_sop, wr_eop, wr_data};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            pkt_cnt_q   <= '0;
            state_q     <= S_IDLE;
            err_ovf_q   <= 1'b0;
            err_udf_q   <= 1'b0;
            err_frame_q <= 1'b0;
            rd_data_q   <= '0;
            rd_sop_q    <= 1'b0;
            rd_eop_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            level_q    <= level_d;
            pkt_cnt_q  <= pkt_cnt_d;
            state_q    <= state_d;
            rd_valid_q <= rd_acc;
            if (wr_acc) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= rd_word[DATA_WIDTH-1:0];
                rd_sop_q  <= rd_word[MW-1];
                rd_eop_q  <= rd_word[DATA_WIDTH];
            end
            if (wr_valid && wr_full) begin
                err_ovf_q <= 1'b1;
            end
            if (rd_en && rd_empty) begin
                err_udf_q <= 1'b1;
            end
            if (frame_viol) begin
                err_frame_q <= 1'b1;
            end
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_sop        = rd_sop_q;
    assign rd_eop        = rd_eop_q;
    assign rd_valid      = rd_valid_q;
    assign level         = level_q;
    assign pkt_cnt       = pkt_cnt_q;
    assign err_ovf       = err_ovf_q;
    assign err_udf       = err_udf_q;
    assign err_frame     = err_frame_q;
    assign frame_state_o = state_q;

endmodule
